// File: rtl/instr_fetch_unit.sv
// Decoupled instruction fetch engine: credit-limited in-order memory requests,
// a prefetch queue, redirect target generation and wrong-path response draining.
module instr_fetch_unit #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned IM_AW    = 12
) (
   input  logic             clk,
   input  logic             reset,
   output logic             imem_req,
   output logic [IM_AW-1:0] imem_addr,
   input  logic             imem_gnt,
   input  logic             imem_rvalid,
   input  logic [31:0]      imem_rdata,
   output logic             ir_valid,
   input  logic             ir_ld,
   output logic [31:0]      IR_out,
   output logic [31:0]      PC_out,
   output logic [31:0]      SE_16,
   input  logic             redirect,
   input  logic [1:0]       PC_sel,
   input  logic [31:0]      PC_In,
   output logic             busy
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned SUM_W = CNT_W + 1;
   localparam logic [SUM_W-1:0] DEPTH_S = SUM_W'(DEPTH);

   typedef enum logic {S_FETCH, S_DRAIN} state_e;

   state_e           state_q, state_d;
   logic             run_q;
   logic [31:0]      fetch_pc_q, fetch_pc_d;
   logic [PTR_W-1:0] q_rd_q, q_rd_d, q_wr_q, q_wr_d;
   logic [CNT_W-1:0] q_cnt_q, q_cnt_d;
   logic [PTR_W-1:0] t_rd_q, t_rd_d, t_wr_q, t_wr_d;
   logic [CNT_W-1:0] infl_q, infl_d;
   logic [CNT_W-1:0] drop_q, drop_d;

   logic [31:0] q_instr [DEPTH];
   logic [31:0] q_pc    [DEPTH];
   logic [31:0] tag_pc  [DEPTH];

   logic        q_empty, redirect_ok, credit_ok, gnt_fire, push, pop;
   logic [31:0] pc4, target;

   always_comb begin
      q_empty  = (q_cnt_q == '0);
      ir_valid = !q_empty;
      IR_out   = q_empty ? '0 : q_instr[q_rd_q];
      PC_out   = q_empty ? '0 : q_pc[q_rd_q];
      SE_16    = {{16{IR_out[15]}}, IR_out[15:0]};
      pc4      = PC_out + 32'd4;
      case (PC_sel)
         2'd1:    target = {pc4[31:28], IR_out[25:0], 2'b00};
         2'd2:    target = pc4 + {SE_16[29:0], 2'b00};
         default: target = PC_In;
      endcase
      // Relative targets need a real head instruction; absolute ones never do.
      redirect_ok = redirect && (ir_valid || PC_sel == 2'd0 || PC_sel == 2'd3);
      credit_ok   = ({1'b0, q_cnt_q} + {1'b0, infl_q}) < DEPTH_S;
      imem_req    = run_q && (state_q == S_FETCH) && credit_ok && !redirect_ok;
      imem_addr   = fetch_pc_q[IM_AW-1:0];
      busy        = (state_q == S_DRAIN);
      gnt_fire    = imem_req && imem_gnt;
      push        = imem_rvalid && (state_q == S_FETCH) && !redirect_ok;
      pop         = ir_ld && ir_valid && !redirect_ok;
   end

   always_comb begin
      // NOTE: every signal written here gets a default first, so no latch is inferred.
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      q_rd_d     = q_rd_q;
      q_wr_d     = q_wr_q;
      q_cnt_d    = q_cnt_q;
      t_rd_d     = t_rd_q;
      t_wr_d     = t_wr_q;
      infl_d     = infl_q;
      drop_d     = drop_q;

      if (gnt_fire) begin
         fetch_pc_d = fetch_pc_q + 32'd4;
         t_wr_d     = t_wr_q + PTR_W'(1);
      end
      if (imem_rvalid) t_rd_d = t_rd_q + PTR_W'(1);
      if (push)        q_wr_d = q_wr_q + PTR_W'(1);
      if (pop)         q_rd_d = q_rd_q + PTR_W'(1);
      q_cnt_d = q_cnt_q + CNT_W'(push) - CNT_W'(pop);

      if (state_q == S_FETCH) begin
         infl_d = infl_q + CNT_W'(gnt_fire) - CNT_W'(imem_rvalid);
      end else if (drop_q == '0) begin
         state_d = S_FETCH;
      end else if (imem_rvalid) begin
         drop_d = drop_q - CNT_W'(1);
         if (drop_q == CNT_W'(1)) state_d = S_FETCH;
      end

      if (redirect_ok) begin
         fetch_pc_d = {target[31:2], 2'b00};
         q_rd_d     = q_wr_q;
         q_wr_d     = q_wr_q;
         q_cnt_d    = '0;
         // Everything still outstanding, including a grant taken this cycle, is wrong-path.
         if (state_q == S_FETCH) begin
            drop_d  = infl_q + CNT_W'(gnt_fire) - CNT_W'(imem_rvalid);
            infl_d  = '0;
            state_d = (drop_d != '0) ? S_DRAIN : S_FETCH;
         end
      end
   end

   // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_FETCH;
         run_q      <= 1'b0;
         fetch_pc_q <= RESET_PC;
         q_rd_q     <= '0;
         q_wr_q     <= '0;
         q_cnt_q    <= '0;
         t_rd_q     <= '0;
         t_wr_q     <= '0;
         infl_q     <= '0;
         drop_q     <= '0;
      end else begin
         state_q    <= state_d;
         run_q      <= 1'b1;
         fetch_pc_q <= fetch_pc_d;
         q_rd_q     <= q_rd_d;
         q_wr_q     <= q_wr_d;
         q_cnt_q    <= q_cnt_d;
         t_rd_q     <= t_rd_d;
         t_wr_q     <= t_wr_d;
         infl_q     <= infl_d;
         drop_q     <= drop_d;
      end
   end

   // NOTE: storage arrays carry no reset; occupancy and pointers alone decide validity.
   always_ff @(posedge clk) begin
      if (push) begin
         q_instr[q_wr_q] <= imem_rdata;
         q_pc[q_wr_q]    <= tag_pc[t_rd_q];
      end
      if (gnt_fire) tag_pc[t_wr_q] <= fetch_pc_q;
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit driven by an in-order, fixed-latency memory model.
module tb_instr_fetch_unit;
   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          IM_AW    = 12;

   logic             clk = 1'b0;
   logic             reset;
   logic             imem_req;
   logic [IM_AW-1:0] imem_addr;
   logic             imem_gnt;
   logic             imem_rvalid;
   logic [31:0]      imem_rdata;
   logic             ir_valid;
   logic             ir_ld;
   logic [31:0]      IR_out;
   logic [31:0]      PC_out;
   logic [31:0]      SE_16;
   logic             redirect;
   logic [1:0]       PC_sel;
   logic [31:0]      PC_In;
   logic             busy;

   instr_fetch_unit #(
      .DEPTH(DEPTH), .RESET_PC(RESET_PC), .IM_AW(IM_AW)
   ) dut (
      .clk(clk), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .ir_valid(ir_valid), .ir_ld(ir_ld), .IR_out(IR_out), .PC_out(PC_out), .SE_16(SE_16),
      .redirect(redirect), .PC_sel(PC_sel), .PC_In(PC_In), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [IM_AW-1:0] addr;
      int               due;
   } pend_t;

   pend_t            pend[$];
   logic [31:0]      mem [1024];
   int               cyc, mem_lat, n_checks, n_pass;
   logic             last_g;
   logic [IM_AW-1:0] last_ga;

   // One clock cycle: drive the memory response, record any grant, advance past the edge.
   task automatic step();
      pend_t p;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
         p = pend.pop_front();
         imem_rvalid = 1'b1;
         imem_rdata  = mem[p.addr[11:2]];
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata  = '0;
      end
      #1;
      last_g  = imem_req && imem_gnt;
      last_ga = imem_addr;
      if (last_g) pend.push_back('{addr: imem_addr, due: cyc + mem_lat});
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      redirect = 1'b0;
      ir_ld    = 1'b0;
      PC_sel   = 2'd0;
      PC_In    = '0;
      pend.delete();
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      @(posedge clk);
      #1;
      n_checks++;
      if (imem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", imem_req);
      else n_pass++;
      n_checks++;
      if (ir_valid !== 1'b0 || busy !== 1'b0)
         $display("FAIL reset_flags: ir_valid=%b busy=%b want 0 0", ir_valid, busy);
      else n_pass++;
      n_checks++;
      if (IR_out !== 32'h0 || PC_out !== 32'h0)
         $display("FAIL reset_ir_pc: IR=%h PC=%h want 0 0", IR_out, PC_out);
      else n_pass++;
      n_checks++;
      if (imem_addr !== RESET_PC[IM_AW-1:0])
         $display("FAIL reset_addr: got %h want %h", imem_addr, RESET_PC[IM_AW-1:0]);
      else n_pass++;
   endtask

   task automatic test_stream();
      int n;
      do_reset();
      mem_lat  = 1;
      imem_gnt = 1'b1;
      ir_ld    = 1'b1;
      n = 0;
      while (imem_req !== 1'b1 && n < 8) begin
         step();
         n++;
      end
      for (int k = 0; k < 10; k++) begin
         n_checks++;
         if (imem_req !== 1'b1 || imem_addr !== 12'(4 * k))
            $display("FAIL stream_issue[%0d]: req=%b addr=%h want req=1 addr=%h",
                     k, imem_req, imem_addr, 12'(4 * k));
         else n_pass++;
         n_checks++;
         if (k >= 2) begin
            if (ir_valid !== 1'b1 || PC_out !== 32'(4 * (k - 2)) || IR_out !== mem[k - 2])
               $display("FAIL stream_head[%0d]: v=%b PC=%h IR=%h want v=1 PC=%h IR=%h",
                        k, ir_valid, PC_out, IR_out, 32'(4 * (k - 2)), mem[k - 2]);
            else n_pass++;
         end else begin
            if (ir_valid !== 1'b0) $display("FAIL stream_latency[%0d]: ir_valid=%b want 0", k, ir_valid);
            else n_pass++;
         end
         step();
      end
      ir_ld = 1'b0;
   endtask

   task automatic test_stall();
      logic [IM_AW-1:0] gq[$];
      do_reset();
      mem_lat  = 1;
      imem_gnt = 1'b1;
      ir_ld    = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (last_g) gq.push_back(last_ga);
      end
      n_checks++;
      if (gq.size() != 4) $display("FAIL stall_grants: got %0d grants want 4", gq.size());
      else n_pass++;
      for (int i = 0; i < gq.size() && i < 4; i++) begin
         n_checks++;
         if (gq[i] !== 12'(4 * i)) $display("FAIL stall_addr[%0d]: got %h want %h", i, gq[i], 12'(4 * i));
         else n_pass++;
      end
      n_checks++;
      if (imem_req !== 1'b0) $display("FAIL stall_req_low: got %b want 0", imem_req);
      else n_pass++;
      n_checks++;
      if (PC_out !== 32'h0 || IR_out !== mem[0])
         $display("FAIL stall_head: PC=%h IR=%h want 0 %h", PC_out, IR_out, mem[0]);
      else n_pass++;
      ir_ld = 1'b1;
      step();
      ir_ld = 1'b0;
      n_checks++;
      if (PC_out !== 32'h4) $display("FAIL stall_pop: PC=%h want 4", PC_out);
      else n_pass++;
      gq.delete();
      for (int i = 0; i < 5; i++) begin
         step();
         if (last_g) gq.push_back(last_ga);
      end
      n_checks++;
      if (gq.size() != 1 || gq[0] !== 12'h010)
         $display("FAIL stall_refill: grants=%0d first=%h want 1 grant at 010", gq.size(),
                  (gq.size() > 0) ? gq[0] : 12'hFFF);
      else n_pass++;
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if (PC_out !== 32'(4 * (k + 1)) || IR_out !== mem[k + 1])
            $display("FAIL stall_order[%0d]: PC=%h IR=%h want %h %h",
                     k, PC_out, IR_out, 32'(4 * (k + 1)), mem[k + 1]);
         else n_pass++;
         ir_ld = 1'b1;
         step();
      end
      ir_ld = 1'b0;
   endtask

   task automatic test_branch();
      mem[8] = 32'h1000_FFFF;
      do_reset();
      mem_lat  = 1;
      imem_gnt = 1'b1;
      ir_ld    = 1'b0;
      redirect = 1'b1;
      PC_sel   = 2'd3;
      PC_In    = 32'h20;
      step();
      redirect = 1'b0;
      for (int i = 0; i < 8; i++) step();
      n_checks++;
      if (PC_out !== 32'h20 || IR_out !== 32'h1000_FFFF || SE_16 !== 32'hFFFF_FFFF)
         $display("FAIL branch_head: PC=%h IR=%h SE=%h want 20 1000ffff ffffffff", PC_out, IR_out, SE_16);
      else n_pass++;
      redirect = 1'b1;
      PC_sel   = 2'd2;
      step();
      redirect = 1'b0;
      n_checks++;
      if (ir_valid !== 1'b0 || busy !== 1'b0)
         $display("FAIL branch_flush: ir_valid=%b busy=%b want 0 0", ir_valid, busy);
      else n_pass++;
      step();
      n_checks++;
      if (last_g !== 1'b1 || last_ga !== 12'h020)
         $display("FAIL branch_target: grant=%b addr=%h want 1 020", last_g, last_ga);
      else n_pass++;
   endtask

   task automatic test_jump();
      mem[4] = 32'h0800_0040;
      do_reset();
      mem_lat  = 1;
      imem_gnt = 1'b1;
      ir_ld    = 1'b0;
      redirect = 1'b1;
      PC_sel   = 2'd0;
      PC_In    = 32'h10;
      step();
      redirect = 1'b0;
      for (int i = 0; i < 8; i++) step();
      n_checks++;
      if (PC_out !== 32'h10 || IR_out !== 32'h0800_0040 || SE_16 !== 32'h0000_0040)
         $display("FAIL jump_head: PC=%h IR=%h SE=%h want 10 08000040 00000040", PC_out, IR_out, SE_16);
      else n_pass++;
      redirect = 1'b1;
      PC_sel   = 2'd1;
      step();
      redirect = 1'b0;
      step();
      n_checks++;
      if (last_g !== 1'b1 || last_ga !== 12'h100)
         $display("FAIL jump_target: grant=%b addr=%h want 1 100", last_g, last_ga);
      else n_pass++;
      for (int i = 0; i < 8; i++) step();
      n_checks++;
      if (PC_out !== 32'h100 || IR_out !== mem[12'h100 >> 2])
         $display("FAIL jump_refill: PC=%h IR=%h want 100 %h", PC_out, IR_out, mem[12'h100 >> 2]);
      else n_pass++;
      redirect = 1'b1;
      PC_sel   = 2'd0;
      PC_In    = 32'h200;
      step();
      // A jump redirect with no head instruction must be ignored.
      PC_sel = 2'd1;
      n_checks++;
      if (ir_valid !== 1'b0) $display("FAIL abs_flush: ir_valid=%b want 0", ir_valid);
      else n_pass++;
      step();
      redirect = 1'b0;
      n_checks++;
      if (last_g !== 1'b1 || last_ga !== 12'h200)
         $display("FAIL abs_target: grant=%b addr=%h want 1 200", last_g, last_ga);
      else n_pass++;
   endtask

   // Leaves the unit one cycle into DRAIN with two stale responses still outstanding.
   task automatic setup_drain(input string tag);
      int ngr;
      int n;
      do_reset();
      mem_lat  = 3;
      imem_gnt = 1'b1;
      ir_ld    = 1'b0;
      ngr = 0;
      n   = 0;
      while (ngr < 3 && n < 12) begin
         step();
         if (last_g) ngr++;
         n++;
      end
      n_checks++;
      if (ngr != 3 || ir_valid !== 1'b0)
         $display("FAIL %s_setup: grants=%0d ir_valid=%b want 3 0", tag, ngr, ir_valid);
      else n_pass++;
      redirect = 1'b1;
      PC_sel   = 2'd0;
      PC_In    = 32'h400;
      step();
      redirect = 1'b0;
      n_checks++;
      if (busy !== 1'b1 || imem_req !== 1'b0 || ir_valid !== 1'b0)
         $display("FAIL %s_enter: busy=%b req=%b v=%b want 1 0 0", tag, busy, imem_req, ir_valid);
      else n_pass++;
   endtask

   task automatic test_drain();
      setup_drain("drain");
      step();
      n_checks++;
      if (busy !== 1'b1 || imem_req !== 1'b0 || ir_valid !== 1'b0)
         $display("FAIL drain_hold: busy=%b req=%b v=%b want 1 0 0", busy, imem_req, ir_valid);
      else n_pass++;
      step();
      n_checks++;
      if (busy !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 12'h400 || ir_valid !== 1'b0)
         $display("FAIL drain_exit: busy=%b req=%b addr=%h v=%b want 0 1 400 0",
                  busy, imem_req, imem_addr, ir_valid);
      else n_pass++;
      step();
      n_checks++;
      if (last_g !== 1'b1 || last_ga !== 12'h400)
         $display("FAIL drain_new_req: grant=%b addr=%h want 1 400", last_g, last_ga);
      else n_pass++;
      step();
      step();
      n_checks++;
      if (ir_valid !== 1'b0) $display("FAIL drain_stale_seen: ir_valid=%b PC=%h want 0", ir_valid, PC_out);
      else n_pass++;
      step();
      n_checks++;
      if (ir_valid !== 1'b1 || PC_out !== 32'h400 || IR_out !== mem[12'h400 >> 2])
         $display("FAIL drain_first: v=%b PC=%h IR=%h want 1 400 %h",
                  ir_valid, PC_out, IR_out, mem[12'h400 >> 2]);
      else n_pass++;
   endtask

   task automatic test_reset_in_drain();
      int n;
      setup_drain("rst_drain");
      reset = 1'b1;
      #1;
      n_checks++;
      if (imem_req !== 1'b0 || busy !== 1'b0 || ir_valid !== 1'b0)
         $display("FAIL rst_drain_flags: req=%b busy=%b v=%b want 0 0 0", imem_req, busy, ir_valid);
      else n_pass++;
      n_checks++;
      if (IR_out !== 32'h0 || PC_out !== 32'h0 || SE_16 !== 32'h0)
         $display("FAIL rst_drain_data: IR=%h PC=%h SE=%h want 0 0 0", IR_out, PC_out, SE_16);
      else n_pass++;
      for (int i = 0; i < 4; i++) step();
      reset = 1'b0;
      n_checks++;
      if (ir_valid !== 1'b0) $display("FAIL rst_drain_ignored: ir_valid=%b want 0", ir_valid);
      else n_pass++;
      n = 0;
      while (imem_req !== 1'b1 && n < 8) begin
         step();
         n++;
      end
      step();
      n_checks++;
      if (last_g !== 1'b1 || last_ga !== RESET_PC[IM_AW-1:0])
         $display("FAIL rst_drain_restart: grant=%b addr=%h want 1 %h", last_g, last_ga, RESET_PC[IM_AW-1:0]);
      else n_pass++;
      n = 0;
      while (ir_valid !== 1'b1 && n < 8) begin
         step();
         n++;
      end
      n_checks++;
      if (ir_valid !== 1'b1 || PC_out !== RESET_PC || IR_out !== mem[0])
         $display("FAIL rst_drain_first: v=%b PC=%h IR=%h want 1 %h %h", ir_valid, PC_out, IR_out, RESET_PC, mem[0]);
      else n_pass++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'hC000_0000 | 32'(i << 2);
      n_checks    = 0;
      n_pass      = 0;
      cyc         = 0;
      mem_lat     = 1;
      reset       = 1'b1;
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      ir_ld       = 1'b0;
      redirect    = 1'b0;
      PC_sel      = 2'd0;
      PC_In       = '0;
      last_g      = 1'b0;
      last_ga     = '0;

      test_reset();
      test_stream();
      test_stall();
      test_branch();
      test_jump();
      test_drain();
      test_reset_in_drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
